// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select.
// Captures decoded fields from ID, forwards MEM/WB results into the operands,
// detects load-use hazards (one-cycle stall plus bubble), honours branch
// flushes and counts inserted bubbles in a saturating counter.
module ex_operand_stage #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [W-1:0]     id_rs1_data,
    input  logic [W-1:0]     id_rs2_data,
    input  logic [W-1:0]     id_imm,
    input  logic [W-1:0]     id_pc,
    input  logic [3:0]       id_alu_ctrl,
    input  logic             id_src_a_pc,
    input  logic             id_src_b_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [W-1:0]     mem_result,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic [W-1:0]     wb_result,
    input  logic             flush,
    output logic             stall_out,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_alu_ctrl,
    output logic [W-1:0]     ex_n1,
    output logic [W-1:0]     ex_n2,
    output logic [W-1:0]     ex_store_data,
    output logic [CNT_W-1:0] bubble_count
);

    logic             valid_q, valid_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic [W-1:0]     rs1_data_q, rs1_data_d;
    logic [W-1:0]     rs2_data_q, rs2_data_d;
    logic [W-1:0]     imm_q, imm_d;
    logic [W-1:0]     pc_q, pc_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic             src_a_pc_q, src_a_pc_d;
    logic             src_b_imm_q, src_b_imm_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

    logic             stall;
    logic             load_bubble;
    logic [W-1:0]     fwd_rs1;
    logic [W-1:0]     fwd_rs2;

    // Load-use hazard: the load in EX writes a register ID wants to read.
    // rs2 is compared even for immediate forms; flush suppresses the stall
    // because the ID instruction is being killed anyway.
    always_comb begin
        stall = ~flush & valid_q & mem_read_q & (rd_q != 5'd0) & id_valid &
                ((id_rs1 == rd_q) | (id_rs2 == rd_q));
        load_bubble = flush | stall;
    end

    // Next-state for the ID/EX register and the saturating bubble counter.
    always_comb begin
        valid_d        = 1'b0;
        rs1_d          = '0;
        rs2_d          = '0;
        rd_d           = '0;
        rs1_data_d     = '0;
        rs2_data_d     = '0;
        imm_d          = '0;
        pc_d           = '0;
        alu_ctrl_d     = 4'b0000;
        src_a_pc_d     = 1'b0;
        src_b_imm_d    = 1'b0;
        reg_write_d    = 1'b0;
        mem_read_d     = 1'b0;
        mem_write_d    = 1'b0;
        bubble_count_d = bubble_count_q;
        if (load_bubble) begin
            if (bubble_count_q != {CNT_W{1'b1}}) begin
                bubble_count_d = bubble_count_q + CNT_W'(1);
            end
        end else begin
            valid_d     = id_valid;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            pc_d        = id_pc;
            alu_ctrl_d  = id_alu_ctrl;
            src_a_pc_d  = id_src_a_pc;
            src_b_imm_d = id_src_b_imm;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
        end
    end

    // ID/EX pipeline register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= 1'b0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            rd_q           <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            imm_q          <= '0;
            pc_q           <= '0;
            alu_ctrl_q     <= 4'b0000;
            src_a_pc_q     <= 1'b0;
            src_b_imm_q    <= 1'b0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            bubble_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            rd_q           <= rd_d;
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
            imm_q          <= imm_d;
            pc_q           <= pc_d;
            alu_ctrl_q     <= alu_ctrl_d;
            src_a_pc_q     <= src_a_pc_d;
            src_b_imm_q    <= src_b_imm_d;
            reg_write_q    <= reg_write_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    // Forwarding: MEM beats WB, x0 is never forwarded.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs1_q)) begin
            fwd_rs1 = mem_result;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs1_q)) begin
            fwd_rs1 = wb_result;
        end
        fwd_rs2 = rs2_data_q;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs2_q)) begin
            fwd_rs2 = mem_result;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs2_q)) begin
            fwd_rs2 = wb_result;
        end
    end

    // Operand select toward the ALU; store data always takes forwarded rs2.
    always_comb begin
        ex_n1         = src_a_pc_q  ? pc_q  : fwd_rs1;
        ex_n2         = src_b_imm_q ? imm_q : fwd_rs2;
        ex_store_data = fwd_rs2;
    end

    assign stall_out    = stall;
    assign ex_valid     = valid_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_mem_write = mem_write_q;
    assign ex_rd        = rd_q;
    assign ex_alu_ctrl  = alu_ctrl_q;
    assign bubble_count = bubble_count_q;

endmodule
